// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector with a run-time programmable PAT_W-bit pattern,
// selectable overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_mealy #(
    parameter int unsigned           PAT_W       = 4,
    parameter logic [PAT_W-1:0]      PAT_DEFAULT = 4'b1011,
    parameter bit                    OVERLAP     = 1'b1,
    parameter int unsigned           CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ARMED
    } state_e;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;

    logic             accept;
    logic [PAT_W-1:0] window;
    logic             hit;

    assign accept = in_valid & ~cfg_we & ~rst;
    // Candidate window: stored history with the current bit appended as LSB.
    assign window = {hist_q, in_bit};
    assign hit    = accept & (state_q == ARMED) & (window == pat_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= PAT_DEFAULT;
            ovl_q   <= OVERLAP;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;

        if (cfg_we) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            fill_d = '0;
            cnt_d  = '0;
        end else if (accept) begin
            hist_d = window[PAT_W-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            if (hit) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping: the matched window's bits must not seed the next match.
                if (!ovl_q) begin
                    fill_d = '0;
                end
            end
        end

        if (fill_d == '0) begin
            state_d = IDLE;
        end else if (fill_d == FILL_MAX) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    // Output logic
    always_comb begin
        match     = hit;
        match_cnt = cnt_q;
        cnt_sat   = &cnt_q;
    end

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Directed scoreboard bench for seq_detect_mealy: a default instance plus a
// CNT_W=2 instance fed the same stream to exercise counter saturation.
module tb_seq_detect_mealy;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       cfg_overlap;

    logic       match;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       match2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] ec  = '0;
    logic [1:0] ec2 = '0;

    typedef struct {
        string      tag;
        logic       m;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];

    seq_detect_mealy u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .match       (match),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat)
    );

    seq_detect_mealy #(.CNT_W(2)) u_dut_c2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .match       (match2),
        .match_cnt   (match_cnt2),
        .cnt_sat     (cnt_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: match is checked before the edge, counters after it.
    task automatic step(input string tag, input logic r, input logic v, input logic b,
                        input logic c, input logic [3:0] cp, input logic co,
                        input logic exp_m);
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; in_bit = b;
        cfg_we = c; cfg_pattern = cp; cfg_overlap = co;
        if (r || c) begin
            ec  = '0;
            ec2 = '0;
        end else if (exp_m) begin
            if (ec != 8'hFF) ec = ec + 8'd1;
            if (ec2 != 2'd3) ec2 = ec2 + 2'd1;
        end
        sb.push_back('{tag, exp_m, ec, ec2});
        #2;
        e = sb.pop_front();
        chk({e.tag, ".match"},  32'(match),  32'(e.m));
        chk({e.tag, ".match2"}, 32'(match2), 32'(e.m));
        @(posedge clk);
        #1;
        chk({e.tag, ".cnt"},  32'(match_cnt),  32'(e.cnt));
        chk({e.tag, ".sat"},  32'(cnt_sat),    32'(&e.cnt));
        chk({e.tag, ".cnt2"}, 32'(match_cnt2), 32'(e.cnt2));
        chk({e.tag, ".sat2"}, 32'(cnt_sat2),   32'(&e.cnt2));
    endtask

    // Feed n valid bits MSB-first with the matching per-bit match expectations.
    task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] exps);
        for (int i = n - 1; i >= 0; i--) begin
            step($sformatf("%s.b%0d", tag, n - i), 1'b0, 1'b1, bits[i], 1'b0, 4'b0, 1'b0, exps[i]);
        end
    endtask

    task automatic cfg(input string tag, input logic [3:0] p, input logic o, input logic b);
        step(tag, 1'b0, 1'b1, b, 1'b1, p, o, 1'b0);
    endtask

    task automatic gap(input string tag);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;

        step("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);

        // 1: default pattern 1011, overlapping
        run_bits("t1", 7, 16'b1011011, 16'b0001001);

        // 2: non-overlapping, matched bits are not reused
        cfg("t2.cfg", 4'b1011, 1'b0, 1'b1);
        run_bits("t2", 7, 16'b1011011, 16'b0001000);

        // 3: invalid gaps hold state and never match
        cfg("t3.cfg", 4'b1011, 1'b1, 1'b1);
        run_bits("t3a", 2, 16'b10, 16'b00);
        gap("t3.g1");
        gap("t3.g2");
        gap("t3.g3");
        run_bits("t3b", 2, 16'b11, 16'b01);

        // 4: reconfigure mid-stream; bit presented with cfg_we is dropped
        run_bits("t4a", 3, 16'b101, 16'b000);
        cfg("t4.cfg", 4'b0000, 1'b1, 1'b0);
        run_bits("t4b", 6, 16'b000000, 16'b000111);

        // 5: counter saturation on the CNT_W=2 instance
        cfg("t5.cfg", 4'b1111, 1'b1, 1'b1);
        run_bits("t5", 8, 16'b11111111, 16'b00011111);

        // 6: reset discards a partial pattern that would otherwise complete
        cfg("t6.cfg", 4'b1011, 1'b1, 1'b0);
        run_bits("t6a", 3, 16'b101, 16'b000);
        step("t6.rst", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0);
        run_bits("t6b", 1, 16'b1, 16'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
